// File: rtl/siso_trellis_sched.sv
// Trellis sequencer: buffers branch-metric pairs while stepping alpha, then replays them in
// reverse for beta. Optional forward-pass watchdog is enabled by defining SISO_SCHED_WDOG_EN.
module siso_trellis_sched #(
  parameter int unsigned ADDR_W      = 13,
  parameter int unsigned MAX_BLKLEN  = 6144,
  parameter int unsigned MIN_BLKLEN  = 40,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [15:0]       i_blklen,
  input  logic              i_valid_branch,
  output logic              o_bm_wr_en,
  output logic [ADDR_W-1:0] o_bm_wr_addr,
  output logic              o_bm_rd_en,
  output logic [ADDR_W-1:0] o_bm_rd_addr,
  output logic              o_alpha_en,
  output logic              o_alpha_init,
  output logic              o_beta_en,
  output logic              o_beta_init,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [1:0] {StIdle, StFwd, StBwd, StFlush} state_e;

  state_e            r_state;
  logic [ADDR_W-1:0] r_len;
  logic [ADDR_W-1:0] r_wr_cnt;
  logic [ADDR_W-1:0] r_rd_cnt;
  logic              r_beta_en;
  logic              r_beta_init;
  logic              r_done;

  logic w_len_ok;
  logic w_wr;
  logic w_last_wr;
  logic w_range_err;
  logic w_ovr_err;
  logic w_wdog;

`ifdef SISO_SCHED_WDOG_EN
  localparam int unsigned IdleW = $clog2(TIMEOUT_CYC + 1);
  logic [IdleW-1:0] r_idle_cnt;
`endif

  always_comb begin
    w_len_ok    = (i_blklen >= 16'(MIN_BLKLEN)) && (i_blklen <= 16'(MAX_BLKLEN));
    w_wr        = (r_state == StFwd) && i_valid_branch;
    w_last_wr   = w_wr && (r_wr_cnt == r_len - ADDR_W'(1));
    w_range_err = (r_state == StIdle) && i_start && !w_len_ok;
    w_ovr_err   = (r_state == StBwd) && i_valid_branch;
`ifdef SISO_SCHED_WDOG_EN
    // Fires in the TIMEOUT_CYC-th consecutive empty cycle of the forward pass
    w_wdog      = (r_state == StFwd) && !i_valid_branch &&
                  (r_idle_cnt == IdleW'(TIMEOUT_CYC - 1));
`else
    w_wdog      = 1'b0;
`endif
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_len       <= '0;
      r_wr_cnt    <= '0;
      r_rd_cnt    <= '0;
      r_beta_en   <= 1'b0;
      r_beta_init <= 1'b0;
      r_done      <= 1'b0;
`ifdef SISO_SCHED_WDOG_EN
      r_idle_cnt  <= '0;
`endif
    end else begin
      // Beta follows the read strobe by the one-cycle buffer latency
      r_beta_en   <= (r_state == StBwd);
      r_beta_init <= (r_state == StBwd) && (r_rd_cnt == r_len - ADDR_W'(1));
      r_done      <= (r_state == StFlush);
      unique case (r_state)
        StIdle: begin
          if (i_start && w_len_ok) begin
            r_len    <= i_blklen[ADDR_W-1:0];
            r_wr_cnt <= '0;
            r_state  <= StFwd;
`ifdef SISO_SCHED_WDOG_EN
            r_idle_cnt <= '0;
`endif
          end
        end
        StFwd: begin
          if (w_wr) begin
            r_wr_cnt <= r_wr_cnt + ADDR_W'(1);
          end
          if (w_last_wr) begin
            r_rd_cnt <= r_len - ADDR_W'(1);
            r_state  <= StBwd;
          end
`ifdef SISO_SCHED_WDOG_EN
          r_idle_cnt <= w_wr ? '0 : r_idle_cnt + IdleW'(1);
          if (w_wdog) r_state <= StIdle;
`endif
        end
        StBwd: begin
          if (r_rd_cnt == '0) r_state <= StFlush;
          else                r_rd_cnt <= r_rd_cnt - ADDR_W'(1);
        end
        StFlush: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  always_comb begin
    o_bm_wr_en   = w_wr;
    o_bm_wr_addr = w_wr ? r_wr_cnt : '0;
    o_alpha_en   = w_wr;
    o_alpha_init = w_wr && (r_wr_cnt == '0);
    o_bm_rd_en   = (r_state == StBwd);
    o_bm_rd_addr = (r_state == StBwd) ? r_rd_cnt : '0;
    o_beta_en    = r_beta_en;
    o_beta_init  = r_beta_init;
    o_busy       = (r_state != StIdle);
    o_done       = r_done;
    o_err        = w_range_err || w_ovr_err || w_wdog;
  end

endmodule
